// File: rtl/core_run_ctrl.sv
// Run sequencer for the 9-bit RISC core.
// Services the host req/ack four-phase handshake: on a request it clears the
// core, enables execution and counts RUN cycles until halt or budget expiry,
// then holds ack until the host drops req. All outputs decode from registered
// state, so req and halt have no combinational path to any output.
module core_run_ctrl #(
  parameter int CLR_CYCLES = 2,
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               halt,
  output logic               ack,
  output logic               busy,
  output logic               core_rst,
  output logic               core_en,
  output logic [CYCLE_W-1:0] cycle_cnt,
  output logic               timeout
);

  // Clear counter only needs to reach CLR_CYCLES-1.
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0]   CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CYCLE_W:0]   MAX_VAL  = (CYCLE_W + 1)'(MAX_CYCLES);
  localparam logic [CYCLE_W-1:0] CNT_ONES = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_reg;
  logic [CLR_W-1:0]   clr_cnt_reg;
  logic [CYCLE_W-1:0] cycle_cnt_reg;
  logic               timeout_reg;

  // One bit wider than the counter so the budget compare cannot wrap.
  logic [CYCLE_W:0] cnt_plus1;
  logic             budget_hit;

  assign cnt_plus1  = {1'b0, cycle_cnt_reg} + {{CYCLE_W{1'b0}}, 1'b1};
  assign budget_hit = (cnt_plus1 == MAX_VAL);

  // Sequencer state, clear counter, cycle counter and timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      clr_cnt_reg   <= '0;
      cycle_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            state_reg     <= CLEAR;
            clr_cnt_reg   <= '0;
            cycle_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
          end
        end
        CLEAR: begin
          // Host abort outranks the clear counter.
          if (!req) begin
            state_reg <= IDLE;
          end else if (clr_cnt_reg == CLR_LAST) begin
            state_reg <= RUN;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        RUN: begin
          // Abort leaves the count untouched; halt and expiry both count
          // the current cycle, and halt beats expiry on the same cycle.
          if (!req) begin
            state_reg <= IDLE;
          end else begin
            if (cycle_cnt_reg != CNT_ONES) begin
              cycle_cnt_reg <= cnt_plus1[CYCLE_W-1:0];
            end
            if (halt) begin
              state_reg <= DONE;
            end else if (budget_hit) begin
              state_reg   <= DONE;
              timeout_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!req) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state. DONE releases core_rst so the
  // host can read back core state after the run.
  assign ack       = (state_reg == DONE);
  assign busy      = (state_reg == CLEAR) || (state_reg == RUN);
  assign core_rst  = (state_reg == IDLE) || (state_reg == CLEAR);
  assign core_en   = (state_reg == RUN);
  assign cycle_cnt = cycle_cnt_reg;
  assign timeout   = timeout_reg;

endmodule
